// File: rtl/uart_pkg.sv
// Constants and FSM encodings shared by the UART transmit and receive paths.
package uart_pkg;
   localparam int CLKS_PER_BIT_DFLT = 18;
   localparam int DATA_BITS_DFLT    = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_e;

   localparam logic LINE_IDLE = 1'b1;
   localparam logic START_LVL = 1'b0;
   localparam logic STOP_LVL  = 1'b1;
endpackage

// File: rtl/uart_tx_serializer_if.sv
// Byte handshake from the producer plus serial line and status from the transmitter.
interface uart_tx_serializer_if;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       transmit;
   logic       busy;

   modport master (output tx_data, tx_valid, input tx_ready, transmit, busy);
   modport slave  (input tx_data, tx_valid, output tx_ready, transmit, busy);
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period counter: pulses bit_end_o on the last cycle of each CLKS_PER_BIT window.
module uart_baud_tick
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DFLT
) (
   input  logic clock,
   input  logic clear,
   input  logic en_i,
   output logic bit_end_o
);
   localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Disabled means parked at zero, so the first enabled cycle is a full bit.
   always_comb begin
      cnt_d = '0;
      if (en_i && (cnt_q != LAST)) cnt_d = cnt_q + CW'(1);
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign bit_end_o = en_i && (cnt_q == LAST);
endmodule

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter: one byte per valid/ready handshake, registered serial output.
//   state | meaning
//   IDLE  | line high, ready for a byte
//   START | start bit (low) for one bit period
//   DATA  | shift[0] on the line, LSB first, 8 bit periods
//   STOP  | stop bit (high) for one bit period
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DFLT,
   parameter int DATA_BITS    = DATA_BITS_DFLT
) (
   input  logic                 clock,
   input  logic                 clear,
   uart_tx_serializer_if.slave  txif
);
   uart_state_e          state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [2:0]           bit_idx_q, bit_idx_d;
   logic                 tx_q, tx_d;
   logic                 busy_q, busy_d;
   logic                 ready_q, ready_d;
   logic                 bit_end;

   uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clock     (clock),
      .clear     (clear),
      .en_i      (state_q != IDLE),
      .bit_end_o (bit_end)
   );

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_idx_d = bit_idx_q;
      case (state_q)
         IDLE: begin
            if (txif.tx_valid && ready_q) begin
               shift_d = txif.tx_data;
               state_d = START;
            end
         end
         START: begin
            if (bit_end) begin
               state_d   = DATA;
               bit_idx_d = '0;
            end
         end
         DATA: begin
            if (bit_end) begin
               shift_d   = shift_q >> 1;
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'(DATA_BITS - 1)) state_d = STOP;
            end
         end
         STOP: begin
            if (bit_end) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Line level is derived from the next state so transmit stays a pure flop output.
      tx_d = LINE_IDLE;
      case (state_d)
         START:   tx_d = START_LVL;
         DATA:    tx_d = shift_d[0];
         STOP:    tx_d = STOP_LVL;
         default: tx_d = LINE_IDLE;
      endcase
      busy_d  = (state_d != IDLE);
      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bit_idx_q <= '0;
         tx_q      <= LINE_IDLE;
         busy_q    <= 1'b0;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_idx_q <= bit_idx_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
         ready_q   <= ready_d;
      end
   end

   assign txif.transmit = tx_q;
   assign txif.busy     = busy_q;
   assign txif.tx_ready = ready_q;
endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
Parallel-to-serial UART transmitter. Accepts one byte per valid/ready handshake and drives the serial line as an 8N1 frame: one start bit, 8 data bits LSB-first, one stop bit. The line idles high. Bit timing matches the receive path: 18 clocks per bit by default (36 ns at the 2 ns bench clock). It is the transmit end of the uart top level and feeds the `transmit` pin.

Parameters:
CLKS_PER_BIT, 18, clock cycles per serial bit; legal range 2..65535.
DATA_BITS, 8, payload bits per frame; fixed at 8 for this release.

Ports:
clock  input  1  system clock; all state changes on rising edge.
clear  input  1  reset; asynchronous, active-high.
tx_data  input  8  byte to send; sampled only on an accepted handshake.
tx_valid  input  1  producer has a byte on tx_data.
tx_ready  output  1  block can accept a byte this cycle.
transmit  output  1  serial line out; registered; idle high.
busy  output  1  high from the cycle after accept through the last stop-bit cycle.

Behaviour:
- Reset values (clear=1, asynchronous, immediate): transmit=1, tx_ready=0 while clear is held, busy=0, state=IDLE, counters=0, shift register=0.
- After clear deasserts, tx_ready=1 from the first clock edge onward.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: tx_ready=1 and transmit=1. Accept when tx_valid && tx_ready at a rising edge. On accept, latch tx_data into an 8-bit shift register, go to START, set busy=1, and set transmit=0 from that edge.
- START: transmit=0 for exactly CLKS_PER_BIT cycles, then go to DATA with bit_idx=0.
- DATA: transmit=shift[0] for CLKS_PER_BIT cycles. At each bit end, shift right and increment bit_idx. After bit_idx=7 completes, go to STOP.
- STOP: transmit=1 for CLKS_PER_BIT cycles, then go to IDLE. busy=0 and tx_ready=1 from that edge.
- Frame length is exactly 10*CLKS_PER_BIT cycles, measured from the accept edge to the return to IDLE.
- Back-to-back frames: minimum one IDLE cycle (transmit=1) between the stop bit and the next start bit. With continuous valid, the period is 10*CLKS_PER_BIT+1 cycles.
- tx_ready=0 in START, DATA and STOP. tx_valid in those states is ignored and causes no accept. tx_data changes after accept do not affect the frame in flight.
- Baud counter: width is clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1, wraps to 0 at each bit end, and is held at 0 in IDLE.
- bit_idx: 3 bits, wraps 7->0 only at the DATA->STOP transition.
- Reset mid-frame aborts the frame: transmit returns to 1 immediately (async), no partial resume, and the next accept starts a fresh frame.
- transmit comes directly from a flop: no combinational path from tx_data or tx_valid, and no glitches.

Decomposition:
- Shared package uart_pkg:
  - CLKS_PER_BIT default (18) and DATA_BITS (8).
  - FSM state encodings IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3.
  - Line levels LINE_IDLE=1, START_LVL=0, STOP_LVL=1.
  - These are shared with the receiver.
- One sub-module: uart_baud_tick, a parameterised counter with enable and clear that emits a one-cycle bit_end pulse every CLKS_PER_BIT cycles. It is reusable by the receiver, which uses a half-bit offset.

Test Plan:
- Reset check: assert clear, then release -> transmit=1, busy=0, tx_ready=1 after the first edge. Assert clear mid-DATA -> transmit=1 within the same time step, and the state returns to IDLE.
- Send 0x55 -> line samples at mid-bit (every 18 clocks) read 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop). busy is high for 180 cycles.
- Send 0x00 then 0xFF with tx_valid held high -> frames 0,0000_0000,1 and 0,1111_1111,1. Exactly one idle-high cycle between frames; second accept 181 cycles after the first.
- Send 0x66 -> data bits on the line are 0,1,1,0,0,1,1,0. Changing tx_data to 0x99 one cycle after accept has no effect on the line.
- tx_valid pulsed during DATA with tx_data=0xAA -> no accept, tx_ready stays 0, and the current frame completes unchanged.
- CLKS_PER_BIT=2 instance, send 0xA5 -> each bit lasts 2 cycles, frame lasts 20 cycles, and data bits read 1,0,1,0,0,1,0,1.
